// File: rtl/fetch_pkg.sv
// Shared geometry, state encoding and line storage type for the fetch responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int ADDR_W     = 32;   // byte address width
    localparam int BEAT_W     = 64;   // backing-memory beat width
    localparam int LINE_BEATS = 4;    // beats per line (32-byte line)
    localparam int WORD_W     = 32;   // instruction word width
    localparam int OFFSET_W   = 5;    // byte offset bits within a line
    localparam int BEAT_IDX_W = 2;    // beat index bits within a line
    localparam int TAG_W      = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        RESP
    } state_t;

    typedef logic [LINE_BEATS-1:0][BEAT_W-1:0] line_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response and burst backing-memory signals bundled together.
// Latency: n/a (wiring only).
// Backpressure: bmem_ready stalls the burst request; the fetch side has none.
// Ports: slave = responder view, master = fetch unit plus backing memory view.
interface imem_responder_if;
    import fetch_pkg::*;

    logic                imem_rqst;
    logic [ADDR_W-1:0]   imem_addr;
    logic [WORD_W-1:0]   imem_rdata;
    logic                imem_resp;
    logic [ADDR_W-1:0]   bmem_addr;
    logic                bmem_read;
    logic                bmem_ready;
    logic [BEAT_W-1:0]   bmem_rdata;
    logic                bmem_rvalid;

    modport slave (
        input  imem_rqst, imem_addr, bmem_ready, bmem_rdata, bmem_rvalid,
        output imem_rdata, imem_resp, bmem_addr, bmem_read
    );

    modport master (
        output imem_rqst, imem_addr, bmem_ready, bmem_rdata, bmem_rvalid,
        input  imem_rdata, imem_resp, bmem_addr, bmem_read
    );

endinterface

// File: rtl/imem_line_buf.sv
// Single-line instruction buffer: tag/valid, beat write port, word-select read mux.
// Latency: lookup and read are combinational; writes land on the next clk edge.
// Backpressure: none; always accepts a beat write.
// Ports: clr_valid/set_tag control validity, wr_* write one beat,
//        lookup_tag -> hit, rd_beat/rd_sel -> rd_word.
module imem_line_buf
    import fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_valid,
    input  logic                  wr_en,
    input  logic [BEAT_IDX_W-1:0] wr_idx,
    input  logic [BEAT_W-1:0]     wr_data,
    input  logic                  set_tag,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic [TAG_W-1:0]      lookup_tag,
    output logic                  hit,
    input  logic [BEAT_IDX_W-1:0] rd_beat,
    input  logic                  rd_sel,
    output logic [WORD_W-1:0]     rd_word
);

    line_t              line_q;
    logic [TAG_W-1:0]   tag_q;
    logic               valid_q;
    logic [BEAT_W-1:0]  beat;

    // Setting the tag marks the line complete; a new refill clears validity
    // so a half-written line can never hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (set_tag) begin
            valid_q <= 1'b1;
            tag_q   <= tag_in;
        end else if (clr_valid) begin
            valid_q <= 1'b0;
        end
    end

    // Data array carries no reset: it is only read while valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_q[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign beat    = line_q[rd_beat];
    assign rd_word = rd_sel ? beat[2*WORD_W-1:WORD_W] : beat[WORD_W-1:0];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: serves words from a one-line buffer, refilling it by burst on a miss.
// Latency: hit 1 cycle; miss = REQ wait for bmem_ready + 4 beats + 1 cycle.
// Backpressure: bmem_ready holds the burst request in REQ; exactly one response per accepted fetch.
// Ports: clk, rst (sync, active high), bus (slave modport of imem_responder_if).
module imem_responder
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    imem_responder_if.slave bus
);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:2]      req_addr_q;      // word-aligned, low bits always zero
    logic [BEAT_IDX_W-1:0]  beat_cnt_q;
    logic [WORD_W-1:0]      rdata_hold_q;

    logic                   accept;
    logic                   issue;
    logic                   beat_wr;
    logic                   fill_last;
    logic                   hit;
    logic                   resp;
    logic                   read;
    logic [WORD_W-1:0]      buf_word;

    // A request is only taken where the fetch unit may legally send one.
    assign accept    = bus.imem_rqst && (state_q == IDLE || state_q == RESP);
    assign issue     = (state_q == REQ) && bus.bmem_ready;
    assign beat_wr   = (state_q == FILL) && bus.bmem_rvalid;
    assign fill_last = beat_wr && (beat_cnt_q == BEAT_IDX_W'(LINE_BEATS - 1));

    imem_line_buf u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .clr_valid  (issue),
        .wr_en      (beat_wr),
        .wr_idx     (beat_cnt_q),
        .wr_data    (bus.bmem_rdata),
        .set_tag    (fill_last),
        .tag_in     (req_addr_q[ADDR_W-1:OFFSET_W]),
        .lookup_tag (bus.imem_addr[ADDR_W-1:OFFSET_W]),
        .hit        (hit),
        .rd_beat    (req_addr_q[OFFSET_W-1:3]),
        .rd_sel     (req_addr_q[2]),
        .rd_word    (buf_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In RESP the hit check runs against the line that just completed, which
    // is already valid, so a chained fetch to the same line hits.
    always_comb begin
        state_d = state_q;
        resp    = 1'b0;
        read    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = hit ? RESP : REQ;
                end
            end
            REQ: begin
                read = 1'b1;
                if (issue) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fill_last) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp = 1'b1;
                if (accept) begin
                    state_d = hit ? RESP : REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q   <= '0;
            beat_cnt_q   <= '0;
            rdata_hold_q <= '0;
        end else begin
            if (accept) begin
                req_addr_q <= bus.imem_addr[ADDR_W-1:2];
            end
            if (issue) begin
                beat_cnt_q <= '0;
            end else if (beat_wr) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            // Keeps the last delivered word visible between responses.
            if (state_q == RESP) begin
                rdata_hold_q <= buf_word;
            end
        end
    end

    assign bus.imem_resp  = resp;
    assign bus.imem_rdata = resp ? buf_word : rdata_hold_q;
    assign bus.bmem_read  = read;
    assign bus.bmem_addr  = {req_addr_q[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};

    // A request while a fetch is outstanding would be dropped silently.
    a_rqst_legal: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rqst |-> (state_q == IDLE || state_q == RESP));

    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        accept |-> (bus.imem_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bursts   = 0;
    int   b0;

    logic [BEAT_W-1:0] line_a [4];
    logic [BEAT_W-1:0] line_b [4];

    imem_responder_if bus ();

    imem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.bmem_read && bus.bmem_ready) bursts++;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", bus.imem_rdata); end
        n_checks++; if (bus.bmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", bus.bmem_read); end
        n_checks++; if (bus.bmem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_baddr: got %h want 00000000", bus.bmem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        b0 = bursts;
        bus.imem_rqst = 1'b1; bus.imem_addr = 32'h0000_1008;
        tick();
        bus.imem_rqst = 1'b0;
        n_checks++; if (bus.bmem_read !== 1'b1) begin n_fail++; $display("FAIL cold_read: got %b want 1", bus.bmem_read); end
        n_checks++; if (bus.bmem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL cold_baddr: got %h want 00001000", bus.bmem_addr); end
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL cold_noresp: got %b want 0", bus.imem_resp); end
        repeat (2) tick();
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        n_checks++; if (bus.bmem_read !== 1'b0) begin n_fail++; $display("FAIL cold_read_drop: got %b want 0", bus.bmem_read); end
        for (int i = 0; i < 4; i++) begin
            bus.bmem_rvalid = 1'b1; bus.bmem_rdata = line_a[i];
            tick();
            if (i < 3) begin
                n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL cold_early_resp: beat %0d got %b want 0", i, bus.imem_resp); end
            end
        end
        bus.bmem_rvalid = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b1) begin n_fail++; $display("FAIL cold_resp: got %b want 1", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL cold_rdata: got %h want 22222222", bus.imem_rdata); end
        tick();
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL cold_single_resp: got %b want 0", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL cold_rdata_hold: got %h want 22222222", bus.imem_rdata); end
        n_checks++; if (bursts - b0 !== 1) begin n_fail++; $display("FAIL cold_bursts: got %0d want 1", bursts - b0); end
    endtask

    task automatic test_hit();
        b0 = bursts;
        bus.imem_rqst = 1'b1; bus.imem_addr = 32'h0000_100C;
        tick();
        bus.imem_rqst = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b1) begin n_fail++; $display("FAIL hit_resp: got %b want 1", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'h3333_3333) begin n_fail++; $display("FAIL hit_rdata: got %h want 33333333", bus.imem_rdata); end
        n_checks++; if (bus.bmem_read !== 1'b0) begin n_fail++; $display("FAIL hit_read: got %b want 0", bus.bmem_read); end
        tick();
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL hit_single_resp: got %b want 0", bus.imem_resp); end
        n_checks++; if (bursts - b0 !== 0) begin n_fail++; $display("FAIL hit_bursts: got %0d want 0", bursts - b0); end
    endtask

    task automatic test_back_to_back();
        bus.imem_rqst = 1'b1; bus.imem_addr = 32'h0000_1004;
        tick();
        n_checks++; if (bus.imem_resp !== 1'b1) begin n_fail++; $display("FAIL b2b_resp1: got %b want 1", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 11111111", bus.imem_rdata); end
        bus.imem_addr = 32'h0000_1010;
        tick();
        bus.imem_rqst = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b1) begin n_fail++; $display("FAIL b2b_resp2: got %b want 1", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'h4444_4444) begin n_fail++; $display("FAIL b2b_rdata2: got %h want 44444444", bus.imem_rdata); end
        tick();
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", bus.imem_resp); end
    endtask

    task automatic test_miss_chained();
        bus.imem_rqst = 1'b1; bus.imem_addr = 32'h0000_1014;
        tick();
        n_checks++; if (bus.imem_rdata !== 32'h5555_5555) begin n_fail++; $display("FAIL chain_first_rdata: got %h want 55555555", bus.imem_rdata); end
        bus.imem_addr = 32'h0000_2000;
        tick();
        bus.imem_rqst = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL chain_stale_resp: got %b want 0", bus.imem_resp); end
        n_checks++; if (bus.bmem_read !== 1'b1) begin n_fail++; $display("FAIL chain_read: got %b want 1", bus.bmem_read); end
        n_checks++; if (bus.bmem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL chain_baddr: got %h want 00002000", bus.bmem_addr); end
    endtask

    // Continues from the REQ state left by test_miss_chained.
    task automatic test_stall_req();
        b0 = bursts;
        bus.bmem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.bmem_read !== 1'b1) begin n_fail++; $display("FAIL stall_read: cycle %0d got %b want 1", i, bus.bmem_read); end
            n_checks++; if (bus.bmem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL stall_baddr: cycle %0d got %h want 00002000", i, bus.bmem_addr); end
            n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL stall_resp: cycle %0d got %b want 0", i, bus.imem_resp); end
            tick();
        end
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        n_checks++; if (bus.bmem_read !== 1'b0) begin n_fail++; $display("FAIL stall_read_drop: got %b want 0", bus.bmem_read); end
        for (int i = 0; i < 4; i++) begin
            bus.bmem_rvalid = 1'b1; bus.bmem_rdata = line_b[i];
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b1) begin n_fail++; $display("FAIL stall_fill_resp: got %b want 1", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL stall_fill_rdata: got %h want aaaaaaaa", bus.imem_rdata); end
        n_checks++; if (bursts - b0 !== 1) begin n_fail++; $display("FAIL stall_bursts: got %0d want 1", bursts - b0); end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        bus.imem_rqst = 1'b1; bus.imem_addr = 32'h0000_1008;
        tick();
        bus.imem_rqst = 1'b0;
        n_checks++; if (bus.bmem_read !== 1'b1) begin n_fail++; $display("FAIL rmf_first_read: got %b want 1", bus.bmem_read); end
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.bmem_rvalid = 1'b1; bus.bmem_rdata = line_a[i];
            tick();
        end
        rst = 1'b1; bus.bmem_rvalid = 1'b1; bus.bmem_rdata = line_a[2];
        tick();
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL rmf_resp_in_rst: got %b want 0", bus.imem_resp); end
        n_checks++; if (bus.bmem_read !== 1'b0) begin n_fail++; $display("FAIL rmf_read_in_rst: got %b want 0", bus.bmem_read); end
        rst = 1'b0; bus.bmem_rdata = line_a[3];
        tick();
        bus.bmem_rvalid = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL rmf_stale_resp: got %b want 0", bus.imem_resp); end
        tick();
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL rmf_idle_resp: got %b want 0", bus.imem_resp); end
        bus.imem_rqst = 1'b1; bus.imem_addr = 32'h0000_1008;
        tick();
        bus.imem_rqst = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b0) begin n_fail++; $display("FAIL rmf_false_hit: got %b want 0", bus.imem_resp); end
        n_checks++; if (bus.bmem_read !== 1'b1) begin n_fail++; $display("FAIL rmf_miss_read: got %b want 1", bus.bmem_read); end
        n_checks++; if (bus.bmem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL rmf_baddr: got %h want 00001000", bus.bmem_addr); end
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bmem_rvalid = 1'b1; bus.bmem_rdata = line_a[i];
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b1) begin n_fail++; $display("FAIL rmf_refill_resp: got %b want 1", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL rmf_refill_rdata: got %h want 22222222", bus.imem_rdata); end
        tick();
    endtask

    task automatic test_repeat_hits();
        b0 = bursts;
        bus.imem_rqst = 1'b1; bus.imem_addr = 32'h0000_1008;
        tick();
        bus.imem_rqst = 1'b0;
        n_checks++; if (bus.imem_resp !== 1'b1) begin n_fail++; $display("FAIL repeat_resp: got %b want 1", bus.imem_resp); end
        n_checks++; if (bus.imem_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL repeat_rdata: got %h want 22222222", bus.imem_rdata); end
        n_checks++; if (bus.bmem_read !== 1'b0) begin n_fail++; $display("FAIL repeat_read: got %b want 0", bus.bmem_read); end
        tick();
        n_checks++; if (bursts - b0 !== 0) begin n_fail++; $display("FAIL repeat_bursts: got %0d want 0", bursts - b0); end
    endtask

    initial begin
        line_a[0] = 64'h1111_1111_0000_0000;
        line_a[1] = 64'h3333_3333_2222_2222;
        line_a[2] = 64'h5555_5555_4444_4444;
        line_a[3] = 64'h7777_7777_6666_6666;
        line_b[0] = 64'hBBBB_BBBB_AAAA_AAAA;
        line_b[1] = 64'hDDDD_DDDD_CCCC_CCCC;
        line_b[2] = 64'hFFFF_FFFF_EEEE_EEEE;
        line_b[3] = 64'h9999_9999_8888_8888;
        rst             = 1'b1;
        bus.imem_rqst   = 1'b0;
        bus.imem_addr   = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;

        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_miss_chained();
        test_stall_req();
        test_reset_mid_fill();
        test_repeat_hits();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the front-end instruction-fetch request/response handshake (imem_rqst/imem_resp).
- Accepts one fetch request at a time and returns a 32-bit instruction word.
- Serves from a single-line buffer on a hit. On a miss, refills that buffer from the burst backing memory (bmem).
- Guarantees exactly one imem_resp per accepted request, never cancelled. The flush logic relies on this to drain the outstanding fetch.

Parameters:
- ADDR_W, 32, byte address width.
- BEAT_W, 64, bmem data beat width.
- LINE_BEATS, 4, beats per cache line; line = 32 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_rqst  in  1  single-cycle request pulse
- imem_addr  in  ADDR_W  fetch byte address; 4-byte aligned; sampled with imem_rqst
- imem_rdata  out  32  instruction word; valid only with imem_resp
- imem_resp  out  1  single-cycle response pulse
- bmem_addr  out  ADDR_W  line-aligned burst address
- bmem_read  out  1  burst read request
- bmem_ready  in  1  bmem can accept a request this cycle
- bmem_rdata  in  BEAT_W  returned beat
- bmem_rvalid  in  1  beat valid; beats arrive in order, beat 0 first

Behaviour:
- Reset:
  - state=IDLE; line_valid=0.
  - imem_resp=0, imem_rdata=0, bmem_read=0, bmem_addr=0.
  - Reset mid-refill abandons the refill. Any beats still arriving afterwards are ignored while in IDLE.
- Address split:
  - tag = addr[ADDR_W-1:5]
  - beat index = addr[4:3]
  - word select = addr[2]
- Accepting a request: in IDLE, or in the RESP cycle, imem_rqst=1 latches imem_addr into req_addr.
- Hit path (line_valid and tag matches):
  - State goes to RESP.
  - Next cycle: imem_resp=1, imem_rdata = selected word from the line buffer.
  - Hit latency is 1 cycle.
- Miss path: state goes to REQ.
- REQ:
  - bmem_read=1, bmem_addr = {req tag, 5'b0}.
  - Both are held until bmem_ready=1. On that cycle the request is issued, beat_cnt=0, and state goes to FILL.
- FILL:
  - Each bmem_rvalid writes bmem_rdata into line[beat_cnt] and increments beat_cnt (2 bits, wraps).
  - line_valid is cleared on entering FILL.
  - On the beat with beat_cnt=LINE_BEATS-1: set the tag, set line_valid=1, go to RESP.
- RESP:
  - imem_resp=1 for exactly one cycle, data from the line buffer.
  - If imem_rqst=1 in the same cycle, the new request is accepted (back-to-back). Next state is RESP on a hit or REQ on a miss, evaluated against the just-filled line.
  - Otherwise the state returns to IDLE.
- imem_rqst outside IDLE/RESP is a protocol violation. It is ignored and flagged by a simulation assertion.
- The same address fetched twice in a row after a miss hits the second time.
- bmem_read must not be asserted outside REQ.
- No flush/cancel input. Responses are always delivered in request order.
- Outside the response cycle, imem_rdata holds its last value.

Decomposition:
- Shared package (fetch_pkg) holds:
  - the line geometry localparams: OFFSET_W=5, BEAT_IDX_W=2
  - the responder state enum: IDLE, REQ, FILL, RESP
  - a line_t typedef: array of LINE_BEATS × BEAT_W
- One natural sub-module, imem_line_buf, covers the tag/valid/data storage, beat write port and word-select read mux. The FSM stays in imem_responder.

Test Plan:
- Cold miss:
  - Stimulus: rqst addr=0x0000_1008; bmem_ready=1 after 2 cycles; beats 0..3 = 0x1111_1111_0000_0000, 0x3333_3333_2222_2222, …
  - Required: bmem_addr=0x0000_1000; resp on the cycle after beat 3; rdata=0x2222_2222.
- Hit:
  - Stimulus: after the cold miss, rqst addr=0x0000_100C.
  - Required: resp exactly 1 cycle later, rdata=0x3333_3333, no bmem_read.
- Back-to-back:
  - Stimulus: rqst asserted in the resp cycle with addr=0x0000_1010 (hit).
  - Required: resp the next cycle; two resps, no idle gap.
- Miss chained in resp cycle:
  - Stimulus: rqst 0x0000_2000 in the resp cycle.
  - Required: bmem_read asserted the next cycle with bmem_addr=0x0000_2000; old line is not served.
- Reset mid-FILL:
  - Stimulus: rst after 2 beats, then remaining beats arrive, then rqst 0x0000_1008.
  - Required: no resp during/after reset from the stale fill; line_valid=0 so the new rqst misses and issues bmem_read.
- Stall at REQ:
  - Stimulus: bmem_ready=0 for 10 cycles.
  - Required: bmem_read and bmem_addr held stable; no resp; exactly one burst issued.
